// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble)
//   feeding the seven-segment scan driver. One operand bit per cycle,
//   32 cycles per conversion, result registered on completion.
//
// Configuration macro:
//   BCD_SIGNED_EN  defined   -> input_data is two's complement; the magnitude
//                               is converted and neg_out carries the sign.
//                  undefined -> input_data is unsigned; neg_out stays 0.
//
// Ports:
//   sys_clk     in   clock, rising edge
//   sys_rst_n   in   asynchronous reset, active HIGH despite the name
//   input_data  in   [IN_W-1:0] operand, sampled on an accepted start
//   start       in   conversion request, accepted only while !busy
//   busy        out  conversion in progress
//   done        out  one-cycle completion pulse
//   bcd_out     out  [DIGITS*4-1:0] BCD result, [3:0] = units digit
//   neg_out     out  operand was negative
//   num_digits  out  [3:0] significant digit count, 1..10
//   ovf4        out  magnitude does not fit in 4 display digits
module bcd_seq_conv #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 10
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [IN_W-1:0]       input_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  neg_out,
  output logic [3:0]            num_digits,
  output logic                  ovf4
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]              state;
  logic [IN_W-1:0]         sreg;
  logic [4:0]              cnt;
  logic                    sign_q;
  logic [DIGITS-1:0][3:0]  acc;
  logic [DIGITS-1:0][3:0]  acc_corr;
  logic [DIGITS*4-1:0]     corr_flat;
  logic [DIGITS*4-1:0]     acc_nxt;
  logic [3:0]              nd_nxt;
  logic                    ovf_nxt;
  logic [IN_W-1:0]         mag;
  logic                    sign_in;

  // Operand conditioning: magnitude and sign captured on start.
`ifdef BCD_SIGNED_EN
  assign sign_in = input_data[IN_W-1];
  // -2^31 negates to itself, which read as unsigned is the right magnitude.
  assign mag     = input_data[IN_W-1] ? (~input_data) + IN_W'(1) : input_data;
`else
  assign sign_in = 1'b0;
  assign mag     = input_data;
`endif

  // Per-digit add-3 correction ahead of the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign acc_corr[g] = (acc[g] >= 4'd5) ? acc[g] + 4'd3 : acc[g];
  end

  assign corr_flat = acc_corr;
  assign acc_nxt   = {corr_flat[DIGITS*4-2:0], sreg[IN_W-1]};

  // Result qualifiers are derived from the value being loaded on the last
  // shift so bcd_out, num_digits and ovf4 always update together.
  always_comb begin
    nd_nxt = 4'd1;
    for (int i = 0; i < DIGITS; i++)
      if (acc_nxt[i*4 +: 4] != 4'd0) nd_nxt = 4'(i + 1);
  end

  assign ovf_nxt = |acc_nxt[DIGITS*4-1:16];
  assign busy    = (state == SHIFT);

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      sign_q     <= 1'b0;
      acc        <= '0;
      done       <= 1'b0;
      bcd_out    <= '0;
      neg_out    <= 1'b0;
      num_digits <= 4'd1;
      ovf4       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg   <= mag;
            sign_q <= sign_in;
            acc    <= '0;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        default: begin
          acc  <= acc_nxt;
          sreg <= {sreg[IN_W-2:0], 1'b0};
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            bcd_out    <= acc_nxt;
            neg_out    <= sign_q;
            num_digits <= nd_nxt;
            ovf4       <= ovf_nxt;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
module tb_bcd_seq_conv;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] input_data;
  logic        start;
  logic        busy, done, neg_out, ovf4;
  logic [39:0] bcd_out;
  logic [3:0]  num_digits;

  bcd_seq_conv #(.IN_W(32), .DIGITS(10)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .input_data(input_data),
    .start(start), .busy(busy), .done(done), .bcd_out(bcd_out),
    .neg_out(neg_out), .num_digits(num_digits), .ovf4(ovf4)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [39:0] bcd;
    logic        neg;
    logic [3:0]  nd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  int   done_cnt = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic exp_t model(input logic [31:0] v);
    exp_t        e;
    logic [31:0] m32;
    longint      m;
    logic [3:0]  d;
`ifdef BCD_SIGNED_EN
    e.neg = v[31];
    m32   = v[31] ? (32'd0 - v) : v;
`else
    e.neg = 1'b0;
    m32   = v;
`endif
    m     = longint'(m32);
    e.ovf = (m > 9999);
    e.bcd = '0;
    e.nd  = 4'd1;
    for (int i = 0; i < 10; i++) begin
      d = 4'(m % 10);
      e.bcd[i*4 +: 4] = d;
      if (d != 4'd0) e.nd = 4'(i + 1);
      m = m / 10;
    end
    e.acc = 0;
    return e;
  endfunction

  // Scoreboard side: every done pops one expectation.
  always @(negedge sys_clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        e = q.pop_front();
        check("bcd_out",    64'(bcd_out),    64'(e.bcd));
        check("neg_out",    64'(neg_out),    64'(e.neg));
        check("num_digits", 64'(num_digits), 64'(e.nd));
        check("ovf4",       64'(ovf4),       64'(e.ovf));
        check("latency",    64'(cyc - e.acc), 64'd32);
        check("busy_at_done", 64'(busy),     64'd0);
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Drives start for one edge from an idle DUT and registers the expectation.
  task automatic start_conv(input logic [31:0] v, output int n);
    exp_t e;
    start = 1'b1;
    input_data = v;
    @(posedge sys_clk);
    #1;
    n = cyc;
    e = model(v);
    e.acc = n;
    q.push_back(e);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      @(negedge sys_clk);
    end
    check("drain", 64'(q.size()), 64'd0);
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int   n;
    int   dc;
    exp_t e;
    logic [31:0] vals [6];
    vals[0] = 32'd1234;
    vals[1] = 32'd0;
    vals[2] = 32'd10000;
    vals[3] = 32'hFFFFFFFF;
    vals[4] = 32'hFFFFFB2E;
    vals[5] = 32'h80000000;

    sys_rst_n  = 1'b1;
    start      = 1'b0;
    input_data = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_bcd",        64'(bcd_out),    64'd0);
    check("rst_neg",        64'(neg_out),    64'd0);
    check("rst_num_digits", 64'(num_digits), 64'd1);
    check("rst_ovf4",       64'(ovf4),       64'd0);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;

    // Directed single conversions.
    for (int k = 0; k < 6; k++) begin
      start_conv(vals[k], n);
      drain();
    end

    // Ignored starts mid-run, then start held through the done cycle.
    start_conv(32'd5678, n);
    input_data = 32'hDEADBEEF;
    wait_cyc(n + 4);
    start = 1'b1; input_data = 32'd99;
    @(posedge sys_clk); #1;
    start = 1'b0; input_data = 32'h12345678;
    wait_cyc(n + 19);
    start = 1'b1; input_data = 32'd99;
    @(posedge sys_clk); #1;
    start = 1'b0;
    wait_cyc(n + 31);
    start = 1'b1; input_data = 32'd4321;
    @(posedge sys_clk); #1;   // edge n+32: done, start ignored
    @(posedge sys_clk); #1;   // edge n+33: accepted
    e = model(32'd4321);
    e.acc = cyc;
    q.push_back(e);
    start = 1'b0;
    check("b2b_accept_cycle", 64'(cyc - n), 64'd33);
    check("b2b_busy", 64'(busy), 64'd1);
    drain();

    // Asynchronous reset mid-conversion.
    start_conv(32'd987654321, n);
    wait_cyc(n + 10);
    #3 sys_rst_n = 1'b1;
    #1;
    q.delete();
    dc = done_cnt;
    check("abort_busy",       64'(busy),       64'd0);
    check("abort_bcd",        64'(bcd_out),    64'd0);
    check("abort_num_digits", 64'(num_digits), 64'd1);
    check("abort_done",       64'(done),       64'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    repeat (40) @(posedge sys_clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(dc));

    start_conv(32'd42, n);
    drain();

    check("done_total", 64'(done_cnt), 64'd9);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
